ram_sync_clear: RTL and testbench

//   Parametrised single-port synchronous RAM, successor to the fixed 16x64 RAM tree.

---
 rtl/ram_sync_clear_if.sv | 26 ++
 rtl/ram_sync_clear.sv | 107 ++++++++++
 tb/tb_ram_sync_clear.sv | 194 +++++++++++++++++++
 3 files changed

// File: rtl/ram_sync_clear_if.sv
// Bus interface for ram_sync_clear: write data, address, read/write
// requests toward the RAM; registered read data, valid strobe and busy back.
interface ram_sync_clear_if #(
  parameter int WIDTH  = 16,
  parameter int ADDR_W = 6
);
  logic [WIDTH-1:0]  in;
  logic [ADDR_W-1:0] addr;
  logic              write;
  logic              read;
  logic [WIDTH-1:0]  out;
  logic              out_valid;
  logic              busy;

  // Requester side
  modport master (
    output in, addr, write, read,
    input  out, out_valid, busy
  );

  // RAM side
  modport slave (
    input  in, addr, write, read,
    output out, out_valid, busy
  );
endinterface

// File: rtl/ram_sync_clear.sv
// ram_sync_clear: parametrised single-port synchronous RAM with a registered
// read port, one-cycle valid strobe and a hardware clear sweep after reset.
// Optional macro RAM_WRITE_THROUGH_EN: same-cycle read+write returns the new
// data (write-first); undefined, the read returns the old word (read-first).
module ram_sync_clear #(
  parameter int              WIDTH     = 16,
  parameter int              ADDR_W    = 6,
  parameter logic [WIDTH-1:0] CLEAR_VAL = '0
) (
  input logic             clk,
  input logic             reset,
  ram_sync_clear_if.slave bus
);

  localparam int unsigned DEPTH = 1 << ADDR_W;

  typedef enum logic {
    ST_CLEAR,
    ST_READY
  } state_e;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0]  out_q, out_d;
  logic              out_valid_q, out_valid_d;

  logic [WIDTH-1:0]  mem [DEPTH];

  logic              mem_we;
  logic [ADDR_W-1:0] mem_waddr;
  logic [WIDTH-1:0]  mem_wdata;
  logic [WIDTH-1:0]  rd_word;

  // Next-state and memory write port: the sweep owns the port while clearing
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    mem_we    = 1'b0;
    mem_waddr = bus.addr;
    mem_wdata = bus.in;
    unique case (state_q)
      ST_CLEAR: begin
        mem_we    = 1'b1;
        mem_waddr = cnt_q;
        mem_wdata = CLEAR_VAL;
        cnt_d     = cnt_q + 1'b1;
        if (cnt_q == '1) begin
          state_d = ST_READY;
        end
      end
      ST_READY: begin
        mem_we = bus.write;
      end
    endcase
    // The sweep restarts from word 0 on reset, so nothing is written meanwhile
    if (reset) begin
      mem_we = 1'b0;
    end
  end

  // Read path: registered data with a one-cycle valid strobe
  always_comb begin
    rd_word     = mem[bus.addr];
    out_d       = out_q;
    out_valid_d = 1'b0;
    if (state_q == ST_READY && bus.read) begin
      out_valid_d = 1'b1;
`ifdef RAM_WRITE_THROUGH_EN
      // Single address port: a concurrent write always targets the read word
      if (bus.write) begin
        out_d = bus.in;
      end else begin
        out_d = rd_word;
      end
`else
      out_d = rd_word;
`endif
    end
  end

  // State, sweep counter and output registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_CLEAR;
      cnt_q       <= '0;
      out_q       <= '0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      out_q       <= out_d;
      out_valid_q <= out_valid_d;
    end
  end

  // Storage array, no reset: contents are defined by the sweep
  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem[mem_waddr] <= mem_wdata;
    end
  end

  assign bus.out       = out_q;
  assign bus.out_valid = out_valid_q;
  assign bus.busy      = (state_q == ST_CLEAR);

endmodule

// File: tb/tb_ram_sync_clear.sv
// Directed bench for ram_sync_clear: a default 16x64 instance and an 8x8
// instance with CLEAR_VAL=8'h5A. Expected read data is queued when a read is
// issued and popped when the registered output should appear.
module tb_ram_sync_clear;

  logic clk;
  logic rst_a;
  logic rst_b;

  int n_cmp  = 0;
  int n_fail = 0;

  ram_sync_clear_if #(.WIDTH(16), .ADDR_W(6)) bus_a ();
  ram_sync_clear_if #(.WIDTH(8),  .ADDR_W(3)) bus_b ();

  ram_sync_clear #(.WIDTH(16), .ADDR_W(6), .CLEAR_VAL(16'h0000)) dut_a (
    .clk   (clk),
    .reset (rst_a),
    .bus   (bus_a)
  );

  ram_sync_clear #(.WIDTH(8), .ADDR_W(3), .CLEAR_VAL(8'h5A)) dut_b (
    .clk   (clk),
    .reset (rst_b),
    .bus   (bus_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference state for instance A
  logic [15:0] mem_a [64];
  int          clear_a = 0;
  logic [15:0] last_a  = '0;
  logic [15:0] exp_a [$];

  // Reference state for instance B
  logic [7:0]  mem_b [8];
  int          clear_b = 0;
  logic [7:0]  last_b  = '0;
  logic [7:0]  exp_b [$];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step_a(input logic rst, input logic w, input logic r,
                        input logic [5:0] a, input logic [15:0] d);
    logic [15:0] e;
    rst_a       = rst;
    bus_a.write = w;
    bus_a.read  = r;
    bus_a.addr  = a;
    bus_a.in    = d;
    if (rst) begin
      clear_a = 64;
      foreach (mem_a[i]) mem_a[i] = 16'h0000;
      last_a = '0;
      exp_a.delete();
    end else if (clear_a > 0) begin
      clear_a--;
    end else begin
      if (r) begin
`ifdef RAM_WRITE_THROUGH_EN
        exp_a.push_back(w ? d : mem_a[a]);
`else
        exp_a.push_back(mem_a[a]);
`endif
      end
      if (w) mem_a[a] = d;
    end
    @(posedge clk);
    #1;
    chk("a_busy", {31'b0, bus_a.busy}, {31'b0, clear_a > 0});
    if (exp_a.size() > 0) begin
      e = exp_a.pop_front();
      chk("a_valid", {31'b0, bus_a.out_valid}, 32'd1);
      chk("a_out", {16'b0, bus_a.out}, {16'b0, e});
      last_a = e;
    end else begin
      chk("a_valid_idle", {31'b0, bus_a.out_valid}, 32'd0);
      chk("a_out_hold", {16'b0, bus_a.out}, {16'b0, last_a});
    end
  endtask

  task automatic step_b(input logic rst, input logic w, input logic r,
                        input logic [2:0] a, input logic [7:0] d);
    logic [7:0] e;
    rst_b       = rst;
    bus_b.write = w;
    bus_b.read  = r;
    bus_b.addr  = a;
    bus_b.in    = d;
    if (rst) begin
      clear_b = 8;
      foreach (mem_b[i]) mem_b[i] = 8'h5A;
      last_b = '0;
      exp_b.delete();
    end else if (clear_b > 0) begin
      clear_b--;
    end else begin
      if (r) begin
`ifdef RAM_WRITE_THROUGH_EN
        exp_b.push_back(w ? d : mem_b[a]);
`else
        exp_b.push_back(mem_b[a]);
`endif
      end
      if (w) mem_b[a] = d;
    end
    @(posedge clk);
    #1;
    chk("b_busy", {31'b0, bus_b.busy}, {31'b0, clear_b > 0});
    if (exp_b.size() > 0) begin
      e = exp_b.pop_front();
      chk("b_valid", {31'b0, bus_b.out_valid}, 32'd1);
      chk("b_out", {24'b0, bus_b.out}, {24'b0, e});
      last_b = e;
    end else begin
      chk("b_valid_idle", {31'b0, bus_b.out_valid}, 32'd0);
      chk("b_out_hold", {24'b0, bus_b.out}, {24'b0, last_b});
    end
  endtask

  initial begin
    rst_a       = 1'b1;
    rst_b       = 1'b1;
    bus_a.write = 1'b0;
    bus_a.read  = 1'b0;
    bus_a.addr  = '0;
    bus_a.in    = '0;
    bus_b.write = 1'b0;
    bus_b.read  = 1'b0;
    bus_b.addr  = '0;
    bus_b.in    = '0;

    // One reset cycle, then 64 sweep cycles; early ones carry ignored requests
    step_a(1'b1, 1'b0, 1'b0, 6'd0, 16'h0);
    for (int i = 0; i < 64; i++) begin
      if (i < 10) step_a(1'b0, 1'b1, 1'b1, 6'd3, 16'hAAAA);
      else        step_a(1'b0, 1'b0, 1'b0, 6'd0, 16'h0);
    end

    // Every word cleared, back-to-back reads
    for (int i = 0; i < 64; i++) step_a(1'b0, 1'b0, 1'b1, 6'(i), 16'h0);
    step_a(1'b0, 1'b0, 1'b0, 6'd0, 16'h0);

    // Write then read, valid for exactly one cycle
    step_a(1'b0, 1'b1, 1'b0, 6'd5, 16'hBEEF);
    step_a(1'b0, 1'b0, 1'b1, 6'd5, 16'h0);
    step_a(1'b0, 1'b0, 1'b0, 6'd0, 16'h0);
    step_a(1'b0, 1'b0, 1'b0, 6'd0, 16'h0);

    // Same-cycle read and write, then a later read
    step_a(1'b0, 1'b1, 1'b0, 6'd9, 16'h1111);
    step_a(1'b0, 1'b1, 1'b1, 6'd9, 16'h2222);
    step_a(1'b0, 1'b0, 1'b1, 6'd9, 16'h0);
    step_a(1'b0, 1'b0, 1'b0, 6'd0, 16'h0);

    // Last word and word written during busy
    step_a(1'b0, 1'b1, 1'b0, 6'd63, 16'hCAFE);
    step_a(1'b0, 1'b0, 1'b1, 6'd63, 16'h0);
    step_a(1'b0, 1'b0, 1'b1, 6'd3, 16'h0);
    step_a(1'b0, 1'b0, 1'b1, 6'd5, 16'h0);
    step_a(1'b0, 1'b0, 1'b0, 6'd0, 16'h0);

    // Reset, 30 sweep cycles, reset again mid-sweep
    step_a(1'b1, 1'b0, 1'b0, 6'd0, 16'h0);
    for (int i = 0; i < 30; i++) step_a(1'b0, 1'b0, 1'b0, 6'd0, 16'h0);
    step_a(1'b1, 1'b0, 1'b0, 6'd0, 16'h0);
    for (int i = 0; i < 64; i++) step_a(1'b0, 1'b1, 1'b1, 6'(i), 16'h5555);
    for (int i = 0; i < 64; i++) step_a(1'b0, 1'b0, 1'b1, 6'(i), 16'h0);
    step_a(1'b0, 1'b0, 1'b0, 6'd0, 16'h0);

    // Small instance: 8-cycle sweep to 8'h5A, then writes at both ends
    step_b(1'b1, 1'b0, 1'b0, 3'd0, 8'h0);
    for (int i = 0; i < 8; i++) step_b(1'b0, 1'b1, 1'b1, 3'd2, 8'hFF);
    for (int i = 0; i < 8; i++) step_b(1'b0, 1'b0, 1'b1, 3'(i), 8'h0);
    step_b(1'b0, 1'b1, 1'b0, 3'd7, 8'h11);
    step_b(1'b0, 1'b1, 1'b0, 3'd0, 8'h22);
    step_b(1'b0, 1'b0, 1'b1, 3'd7, 8'h0);
    step_b(1'b0, 1'b0, 1'b1, 3'd0, 8'h0);
    step_b(1'b0, 1'b0, 1'b1, 3'd4, 8'h0);
    step_b(1'b0, 1'b0, 1'b0, 3'd0, 8'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
